// File: rtl/timer_pkg.sv
// Shared timer definitions: TCR field positions, clock-select codes,
// counter controller FSM states and the counter width.
package timer_pkg;

  // Counter / TDR data width
  localparam int CNT_WIDTH = 8;

  // Prescaler width (divide by 2, 4, 8 or 16)
  localparam int PRESC_WIDTH = 4;

  // Bit positions of the counter controls inside the timer control register
  localparam int TCR_LOAD_BIT    = 7;
  localparam int TCR_UP_DOWN_BIT = 5;
  localparam int TCR_EN_BIT      = 4;
  localparam int TCR_CKS_MSB     = 1;
  localparam int TCR_CKS_LSB     = 0;

  // Clock-select encodings (TCR[1:0])
  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

  // Counter controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_COUNT = 2'b10
  } state_e;

  // Low-order prescaler bits that must all be ones for a tick at a given
  // clock select: /2 -> bit 0, /4 -> bits 1:0, /8 -> bits 2:0, /16 -> bits 3:0
  function automatic logic [PRESC_WIDTH-1:0] cks_mask(input cks_e cks);
    logic [PRESC_WIDTH-1:0] mask;
    mask = '0;
    case (cks)
      CKS_DIV2:  mask = PRESC_WIDTH'(4'b0001);
      CKS_DIV4:  mask = PRESC_WIDTH'(4'b0011);
      CKS_DIV8:  mask = PRESC_WIDTH'(4'b0111);
      default:   mask = PRESC_WIDTH'(4'b1111);
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Free-running prescaler for the timer counter. Counts while inc is high,
// returns to zero whenever clear is high, and produces a single-cycle tick
// each time the low cks+1 bits are all ones.
import timer_pkg::*;

module cnt_prescaler #(
  parameter int DIV_W = PRESC_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  input  logic [1:0] cks,
  output logic       tick
);

  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;
  logic [DIV_W-1:0] mask;

  // Select which low-order prescaler bits form the current division ratio
  always_comb begin
    mask = DIV_W'(cks_mask(cks_e'(cks)));
  end

  // Next prescaler value: clear has priority, otherwise advance while counting
  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (inc) begin
      presc_d = presc_q + DIV_W'(1);
    end
  end

  // Tick straight off the registered prescaler so a cks change acts at once
  always_comb begin
    tick = inc & ((presc_q & mask) == mask);
  end

  // Prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/cnt_ctrl.sv
// Timer counter controller. Decodes load/enable from the live TCR fields,
// runs the prescaler, steps the counter up or down on each tick and keeps
// the sticky overflow/underflow status bits for the TSR.
import timer_pkg::*;

module cnt_ctrl #(
  parameter int WIDTH = CNT_WIDTH,
  parameter int DIV_W = PRESC_WIDTH
) (
  input  logic             cnt_clk,
  input  logic             cnt_reset_n,
  input  logic             cnt_load,
  input  logic             cnt_up_down,
  input  logic             cnt_en,
  input  logic [1:0]       cnt_cks,
  input  logic [WIDTH-1:0] cnt_tdr,
  input  logic             cnt_ovf_clr,
  input  logic             cnt_udf_clr,
  output logic [WIDTH-1:0] cnt_value,
  output logic             cnt_ovf,
  output logic             cnt_udf,
  output logic             cnt_tick,
  output logic [1:0]       cnt_state
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             udf_q;
  logic             udf_d;
  logic             set_ovf;
  logic             set_udf;
  logic             count_en;
  logic             presc_clear;
  logic             tick;

  // Counting is allowed only when enabled and not being overridden by load
  always_comb begin
    count_en    = cnt_en & ~cnt_load;
    presc_clear = ~count_en;
  end

  cnt_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (cnt_clk),
    .rst_n (cnt_reset_n),
    .clear (presc_clear),
    .inc   (count_en),
    .cks   (cnt_cks),
    .tick  (tick)
  );

  // Next state: load beats enable, otherwise fall back to idle
  always_comb begin
    state_d = ST_IDLE;
    if (cnt_load) begin
      state_d = ST_LOAD;
    end else if (cnt_en) begin
      state_d = ST_COUNT;
    end
  end

  // Counter update decoded from the live inputs; wrap detection raises set strobes
  always_comb begin
    value_d = value_q;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    if (cnt_load) begin
      value_d = cnt_tdr;
    end else if (tick) begin
      if (!cnt_up_down) begin
        value_d = value_q + WIDTH'(1);
        set_ovf = (value_q == {WIDTH{1'b1}});
      end else begin
        value_d = value_q - WIDTH'(1);
        set_udf = (value_q == '0);
      end
    end
  end

  // Sticky status: a set in the same cycle as a clear keeps the flag high
  always_comb begin
    ovf_d = set_ovf | (ovf_q & ~cnt_ovf_clr);
    udf_d = set_udf | (udf_q & ~cnt_udf_clr);
  end

  // State, counter and flag registers
  always_ff @(posedge cnt_clk or negedge cnt_reset_n) begin
    if (!cnt_reset_n) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Drive the observable outputs from the registered state
  always_comb begin
    cnt_value = value_q;
    cnt_ovf   = ovf_q;
    cnt_udf   = udf_q;
    cnt_tick  = tick;
    cnt_state = state_q;
  end

endmodule

// File: tb/tb_cnt_ctrl.sv
// Directed self-checking bench for the timer counter controller.
module tb_cnt_ctrl;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic       up_down;
  logic       en;
  logic [1:0] cks;
  logic [7:0] tdr;
  logic       ovf_clr;
  logic       udf_clr;
  logic [7:0] value;
  logic       ovf;
  logic       udf;
  logic       tick;
  logic [1:0] state;

  int checks = 0;
  int passes = 0;

  cnt_ctrl #(.WIDTH(8), .DIV_W(4)) dut (
    .cnt_clk     (clk),
    .cnt_reset_n (rst_n),
    .cnt_load    (load),
    .cnt_up_down (up_down),
    .cnt_en      (en),
    .cnt_cks     (cks),
    .cnt_tdr     (tdr),
    .cnt_ovf_clr (ovf_clr),
    .cnt_udf_clr (udf_clr),
    .cnt_value   (value),
    .cnt_ovf     (ovf),
    .cnt_udf     (udf),
    .cnt_tick    (tick),
    .cnt_state   (state)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 0; up_down = 0; en = 0; cks = 2'b00;
    tdr = 8'h00; ovf_clr = 0; udf_clr = 0;
    #3;
    checks++; if (value !== 8'h00) $display("[TB] FAIL reset_value got=%h exp=00", value); else passes++;
    checks++; if (ovf !== 1'b0 || udf !== 1'b0) $display("[TB] FAIL reset_flags got=%b%b exp=00", ovf, udf); else passes++;
    checks++; if (state !== 2'b00 || tick !== 1'b0) $display("[TB] FAIL reset_state got=%b tick=%b exp=00 tick=0", state, tick); else passes++;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_load_priority();
    tdr = 8'hA5; load = 1; en = 1; cks = 2'b00; up_down = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if (value !== 8'hA5 || tick !== 1'b0) $display("[TB] FAIL load_hold cyc=%0d got=%h tick=%b exp=a5 tick=0", i, value, tick); else passes++;
      checks++; if (state !== 2'b01) $display("[TB] FAIL load_state cyc=%0d got=%b exp=01", i, state); else passes++;
    end
    load = 0;
    step(1);
    checks++; if (value !== 8'hA5 || state !== 2'b10) $display("[TB] FAIL load_release1 got=%h st=%b exp=a5 st=10", value, state); else passes++;
    step(1);
    checks++; if (value !== 8'hA6) $display("[TB] FAIL load_release2 got=%h exp=a6", value); else passes++;
    en = 0;
    step(1);
  endtask

  task automatic test_up_overflow();
    tdr = 8'hFE; load = 1; en = 0;
    step(1);
    load = 0; en = 1; up_down = 0; cks = 2'b00;
    step(2);
    checks++; if (value !== 8'hFF || ovf !== 1'b0) $display("[TB] FAIL ovf_edge2 got=%h ovf=%b exp=ff ovf=0", value, ovf); else passes++;
    step(1);
    checks++; if (value !== 8'hFF || ovf !== 1'b0) $display("[TB] FAIL ovf_edge3 got=%h ovf=%b exp=ff ovf=0", value, ovf); else passes++;
    step(1);
    checks++; if (value !== 8'h00 || ovf !== 1'b1) $display("[TB] FAIL ovf_wrap got=%h ovf=%b exp=00 ovf=1", value, ovf); else passes++;
    step(2);
    checks++; if (value !== 8'h01 || ovf !== 1'b1) $display("[TB] FAIL ovf_sticky got=%h ovf=%b exp=01 ovf=1", value, ovf); else passes++;
    en = 0;
    step(1);
  endtask

  task automatic test_set_clear_collision();
    ovf_clr = 1;
    step(1);
    ovf_clr = 0;
    checks++; if (ovf !== 1'b0) $display("[TB] FAIL ovf_clear got=%b exp=0", ovf); else passes++;
    tdr = 8'hFF; load = 1;
    step(1);
    load = 0; en = 1; cks = 2'b00; up_down = 0;
    step(1);
    ovf_clr = 1;
    step(1);
    checks++; if (value !== 8'h00 || ovf !== 1'b1) $display("[TB] FAIL collision got=%h ovf=%b exp=00 ovf=1", value, ovf); else passes++;
    step(1);
    ovf_clr = 0;
    checks++; if (ovf !== 1'b0 || value !== 8'h00) $display("[TB] FAIL clear_after got=%h ovf=%b exp=00 ovf=0", value, ovf); else passes++;
    en = 0;
    step(1);
  endtask

  task automatic test_down_underflow();
    tdr = 8'h01; load = 1;
    step(1);
    load = 0; en = 1; up_down = 1; cks = 2'b11;
    step(15);
    checks++; if (value !== 8'h01 || tick !== 1'b1) $display("[TB] FAIL udf_pre got=%h tick=%b exp=01 tick=1", value, tick); else passes++;
    step(1);
    checks++; if (value !== 8'h00 || udf !== 1'b0) $display("[TB] FAIL udf_16 got=%h udf=%b exp=00 udf=0", value, udf); else passes++;
    step(15);
    checks++; if (value !== 8'h00) $display("[TB] FAIL udf_31 got=%h exp=00", value); else passes++;
    step(1);
    checks++; if (value !== 8'hFF || udf !== 1'b1 || ovf !== 1'b0) $display("[TB] FAIL udf_32 got=%h udf=%b ovf=%b exp=ff udf=1 ovf=0", value, udf, ovf); else passes++;
    en = 0; udf_clr = 1;
    step(1);
    udf_clr = 0;
    checks++; if (udf !== 1'b0 || value !== 8'hFF) $display("[TB] FAIL udf_clear got=%h udf=%b exp=ff udf=0", value, udf); else passes++;
  endtask

  task automatic test_en_pause();
    tdr = 8'h0F; load = 1;
    step(1);
    load = 0; en = 1; up_down = 0; cks = 2'b10;
    step(7);
    checks++; if (value !== 8'h0F) $display("[TB] FAIL pause_pre got=%h exp=0f", value); else passes++;
    step(1);
    checks++; if (value !== 8'h10) $display("[TB] FAIL pause_first got=%h exp=10", value); else passes++;
    step(3);
    en = 0;
    step(5);
    checks++; if (value !== 8'h10 || state !== 2'b00 || tick !== 1'b0) $display("[TB] FAIL pause_hold got=%h st=%b tick=%b exp=10 st=00 tick=0", value, state, tick); else passes++;
    en = 1;
    step(7);
    checks++; if (value !== 8'h10) $display("[TB] FAIL resume_7 got=%h exp=10", value); else passes++;
    step(1);
    checks++; if (value !== 8'h11 || state !== 2'b10) $display("[TB] FAIL resume_8 got=%h st=%b exp=11 st=10", value, state); else passes++;
    en = 0;
    step(1);
  endtask

  task automatic test_reset_mid_count();
    tdr = 8'hFF; load = 1;
    step(1);
    load = 0; en = 1; up_down = 0; cks = 2'b00;
    step(2);
    tdr = 8'h05; load = 1;
    step(1);
    load = 0;
    step(1);
    checks++; if (value !== 8'h05 || ovf !== 1'b1) $display("[TB] FAIL prereset got=%h ovf=%b exp=05 ovf=1", value, ovf); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (value !== 8'h00 || ovf !== 1'b0 || udf !== 1'b0) $display("[TB] FAIL async_reset got=%h ovf=%b udf=%b exp=00 0 0", value, ovf, udf); else passes++;
    checks++; if (state !== 2'b00 || tick !== 1'b0) $display("[TB] FAIL async_reset_state got=%b tick=%b exp=00 tick=0", state, tick); else passes++;
    en = 0;
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset();
    test_load_priority();
    test_up_overflow();
    test_set_clear_collision();
    test_down_underflow();
    test_en_pause();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard stop so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/cnt_ctrl.md
Name: cnt_ctrl

Overview:
Counter controller/sequencer for the timer. It consumes the configuration fields held in the timer control register (load, up_down, en, cks) and the TDR reload value. It runs the prescaler and the 8-bit counter, and raises sticky overflow/underflow status toward the status register. It sits between the APB register slice (TCR/TDR/TSR) and the interrupt logic.

Parameters:
WIDTH, 8, counter/TDR data width
DIV_W, 4, prescaler width; supports division by 2, 4, 8 or 16

Ports:
cnt_clk  in  1  system clock; all state on rising edge
cnt_reset_n  in  1  asynchronous active-low reset
cnt_load  in  1  TCR[7]; level; load TDR into the counter
cnt_up_down  in  1  TCR[5]; 0 = count up, 1 = count down
cnt_en  in  1  TCR[4]; counting enable
cnt_cks  in  2  TCR[1:0]; clock select: 00 = /2, 01 = /4, 10 = /8, 11 = /16
cnt_tdr  in  WIDTH  reload value from TDR
cnt_ovf_clr  in  1  one-cycle strobe; clears the overflow flag (TSR write-1-to-clear)
cnt_udf_clr  in  1  one-cycle strobe; clears the underflow flag
cnt_value  out  WIDTH  current counter value (TCNT)
cnt_ovf  out  1  sticky overflow flag
cnt_udf  out  1  sticky underflow flag
cnt_tick  out  1  registered-path prescaler tick, one cycle wide (debug/observability)
cnt_state  out  2  FSM state: 00 IDLE, 01 LOAD, 10 COUNT

Behaviour:
- Reset (async, cnt_reset_n=0): cnt_value=0, cnt_ovf=0, cnt_udf=0, prescaler=0, cnt_tick=0, state=IDLE. Effect is immediate, independent of the clock. Any operation in flight is abandoned.
- FSM next state, evaluated every edge, with priority top-down:
  - cnt_load=1 -> LOAD
  - else cnt_en=1 -> COUNT
  - else -> IDLE
- Actions are decoded from the current inputs with the same priority, not from the registered state. The state output lags the inputs by one cycle.
- LOAD: cnt_value <= cnt_tdr at the next edge, held every cycle while cnt_load=1. Load overrides cnt_en. Load never sets either flag. Prescaler is cleared to 0.
- IDLE (load=0, en=0): cnt_value holds, prescaler is cleared to 0, no ticks.
- Prescaler: DIV_W-bit free counter, incremented each cycle only while en=1 and load=0.
  - tick = en & !load & (prescaler[cks:0] all ones). Combinational off the prescaler register; drives cnt_tick.
  - First tick comes 2^(cks+1) cycles after en is first sampled high. The first counter change is visible at edge 2^(cks+1) (e.g. /2 -> edge 2, /16 -> edge 16).
  - A cks change mid-count takes effect immediately using the same formula; a shortened first period is acceptable.
- Count on tick, up (up_down=0): cnt_value+1. If cnt_value is all ones, it wraps to 0 and the overflow set fires.
- Count on tick, down (up_down=1): cnt_value-1. If cnt_value is 0, it wraps to all ones and the underflow set fires.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- Flags:
  - ovf <= set_ovf | (ovf & !ovf_clr); same form for udf.
  - Set and clear in the same cycle: set wins, flag stays 1.
  - Clear while already 0: no effect.
  - Flags are unaffected by load and by en=0.
- Changing up_down mid-count applies from the next tick. No extra or skipped counts.

Decomposition:
- Shared package timer_pkg holds:
  - TCR bit indices: LOAD=7, UP_DOWN=5, EN=4, CKS=1:0.
  - cks encodings.
  - FSM state encodings: IDLE/LOAD/COUNT.
  - Counter width constant.
- One sub-module: cnt_prescaler (DIV_W counter, clear input, cks select, tick output).
- The top level holds the FSM, counter and flags.

Test Plan:
- Reset mid-count: en=1, cks=00, counting at 8'h05; pulse cnt_reset_n low asynchronously -> cnt_value=0, ovf=udf=0, state=IDLE at once, no clock edge needed.
- Load priority: tdr=8'hA5, load=1, en=1 for 3 cycles -> cnt_value=8'hA5 after first edge and constant, no ticks, state=LOAD. Drop load -> first increment to 8'hA6 two edges later (cks=00).
- Up overflow: load 8'hFE, en=1, up, cks=00 -> 8'hFF at edge 2, 8'h00 at edge 4 with ovf=1. Flag stays set through further counts.
- Down underflow timing: load 8'h01, down, cks=11 -> 8'h00 after 16 cycles, 8'hFF after 32 cycles, udf=1, ovf unchanged.
- Set/clear collision: cnt_ovf_clr pulsed on the exact wrap cycle -> ovf remains 1. Pulse ovf_clr alone the next cycle -> ovf=0.
- en deassert/reassert with cks=10: stop at value 8'h10 mid-period -> value holds, prescaler cleared. Re-enable -> next increment exactly 8 cycles later.
